// File: rtl/osnt_ipif_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// osnt_ipif_pkg
// Shared definitions for the IPIF register bank.
//   state_t         access FSM encoding (IDLE/DECODE/ACK/WAIT)
//   UNMAPPED_RDATA  value returned by a read of an unmapped offset
//   offset_evt()    word offset of the sticky event register, which sits
//                   directly after the RW and RO blocks
//   be_to_mask()    expands 4 byte enables into a 32-bit bit mask
// ---------------------------------------------------------------------------
package osnt_ipif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACK    = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  function automatic int offset_evt(input int num_rw, input int num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/osnt_ipif_reg_bank_if.sv
// ---------------------------------------------------------------------------
// osnt_ipif_reg_bank_if
// IPIF strobe bundle between the AXI-Lite-to-IPIF bridge and a register bank.
//   Bus2IP_Addr/CS/RNW/Data/BE   bridge -> bank request
//   IP2Bus_Data/RdAck/WrAck/Error bank -> bridge response
// Modports: master = bridge side, slave = register-bank side.
// ---------------------------------------------------------------------------
interface osnt_ipif_reg_bank_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   Bus2IP_Addr;
  logic                Bus2IP_CS;
  logic                Bus2IP_RNW;
  logic [DATA_W-1:0]   Bus2IP_Data;
  logic [DATA_W/8-1:0] Bus2IP_BE;
  logic [DATA_W-1:0]   IP2Bus_Data;
  logic                IP2Bus_RdAck;
  logic                IP2Bus_WrAck;
  logic                IP2Bus_Error;

  modport master (
    output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

endinterface

// File: rtl/osnt_ipif_reg_bank_w1c.sv
// ---------------------------------------------------------------------------
// osnt_w1c_reg
// 32-bit sticky event register with write-1-to-clear.
//   clk, rst  clock, asynchronous active-high reset (clears q)
//   set_vec   per-bit set pulses, OR-ed in every cycle
//   clr_en    qualifies a W1C write this cycle
//   clr_vec   write data; a 1 clears the bit
//   be        byte enables gating clr_vec
//   q         register contents
// A set and a clear on the same bit in the same cycle leave the bit set.
// ---------------------------------------------------------------------------
module osnt_w1c_reg
  import osnt_ipif_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] set_vec,
  input  logic        clr_en,
  input  logic [31:0] clr_vec,
  input  logic [3:0]  be,
  output logic [31:0] q
);

  logic [31:0] q_reg;
  logic [31:0] q_next;
  logic [31:0] clr_mask;

  assign clr_mask = clr_en ? (clr_vec & be_to_mask(be)) : 32'h0;
  // Clear first, then OR the set vector so a coincident set wins.
  assign q_next   = (q_reg & ~clr_mask) | set_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_reg <= '0;
    else     q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/osnt_ipif_reg_bank.sv
// ---------------------------------------------------------------------------
// osnt_ipif_reg_bank
// Register bank sitting behind the AXI-Lite-to-IPIF bridge.
//   Bus2IP_Clk    single clock
//   Bus2IP_Reset  asynchronous active-high reset
//   bus           IPIF request/response bundle (slave side)
//   rw_regs       C_NUM_RW control registers, reg k at [32k+31:32k]
//   ro_regs       C_NUM_RO status inputs, sampled in the decode cycle
//   evt_set       sticky event set pulses
//   evt_status    sticky event register (W1C at offset C_NUM_RW+C_NUM_RO)
// Each CS assertion yields exactly one single-cycle RdAck or WrAck two
// cycles after CS is first seen; the FSM then waits for CS to drop.
// ---------------------------------------------------------------------------
module osnt_ipif_reg_bank
  import osnt_ipif_pkg::*;
#(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h0000_0000,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = 32'h0000_0FFF,
  parameter int                            C_NUM_RW           = 8,
  parameter int                            C_NUM_RO           = 8,
  parameter logic [31:0]                   C_RW_RESET         = 32'h0000_0000
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Reset,
  osnt_ipif_reg_bank_if.slave   bus,
  output logic [32*C_NUM_RW-1:0] rw_regs,
  input  logic [32*C_NUM_RO-1:0] ro_regs,
  input  logic [31:0]           evt_set,
  output logic [31:0]           evt_status
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] EVT_OFF = AW'(offset_evt(C_NUM_RW, C_NUM_RO));

  // ---------------- FSM ----------------
  state_t state_reg;
  state_t state_next;

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) state_reg <= ST_IDLE;
    else              state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.Bus2IP_CS) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_ACK;
      ST_ACK:    state_next = ST_WAIT;
      // Hold here until the bridge releases CS so one request gets one ack.
      ST_WAIT:   if (!bus.Bus2IP_CS) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // ---------------- Address decode ----------------
  // The extra MSB of the difference is the borrow: set when Addr < BASE.
  logic [AW:0]   addr_diff;
  logic [AW-1:0] off;
  logic          in_range;

  assign addr_diff = {1'b0, bus.Bus2IP_Addr} - {1'b0, C_BASEADDR};
  assign off       = addr_diff[AW-1:0] >> 2;
  assign in_range  = !addr_diff[AW] && (bus.Bus2IP_Addr <= C_HIGHADDR);

  logic [C_NUM_RW-1:0] rw_sel;
  logic                evt_hit;
  logic                mapped;
  logic [DW-1:0]       rd_mux;

  always_comb begin
    rw_sel  = '0;
    evt_hit = 1'b0;
    mapped  = 1'b0;
    rd_mux  = UNMAPPED_RDATA;
    if (in_range) begin
      for (int k = 0; k < C_NUM_RW; k++) begin
        if (off == AW'(k)) begin
          rw_sel[k] = 1'b1;
          mapped    = 1'b1;
          rd_mux    = rw_regs[32*k +: 32];
        end
      end
      for (int k = 0; k < C_NUM_RO; k++) begin
        if (off == AW'(C_NUM_RW + k)) begin
          mapped = 1'b1;
          rd_mux = ro_regs[32*k +: 32];
        end
      end
      if (off == EVT_OFF) begin
        evt_hit = 1'b1;
        mapped  = 1'b1;
        rd_mux  = evt_status;
      end
    end
  end

  // ---------------- Request capture (DECODE cycle) ----------------
  logic                rnw_reg;
  logic                err_reg;
  logic                evt_sel_reg;
  logic [C_NUM_RW-1:0] rw_sel_reg;
  logic [DW-1:0]       wdata_reg;
  logic [3:0]          be_reg;
  logic [DW-1:0]       rd_data_reg;

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      rnw_reg     <= 1'b0;
      err_reg     <= 1'b0;
      evt_sel_reg <= 1'b0;
      rw_sel_reg  <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      rd_data_reg <= '0;
    end else if (state_reg == ST_DECODE) begin
      rnw_reg     <= bus.Bus2IP_RNW;
      err_reg     <= !mapped;
      evt_sel_reg <= evt_hit;
      rw_sel_reg  <= rw_sel;
      wdata_reg   <= bus.Bus2IP_Data;
      be_reg      <= bus.Bus2IP_BE;
      // Only reads update the return data, so it holds between read acks.
      if (bus.Bus2IP_RNW) rd_data_reg <= rd_mux;
    end
  end

  // ---------------- Response ----------------
  logic ack_cycle;
  logic wr_commit;

  assign ack_cycle = (state_reg == ST_ACK);
  assign wr_commit = ack_cycle && !rnw_reg;

  assign bus.IP2Bus_RdAck = ack_cycle && rnw_reg;
  assign bus.IP2Bus_WrAck = ack_cycle && !rnw_reg;
  assign bus.IP2Bus_Error = ack_cycle && err_reg;
  assign bus.IP2Bus_Data  = rd_data_reg;

  // ---------------- RW registers ----------------
  // rw_sel_reg is all-zero for RO, EVT and unmapped offsets, so those
  // writes never touch this array.
  logic [31:0] wmask;
  assign wmask = be_to_mask(be_reg);

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_RW; gi++) begin : g_rw
      logic [31:0] word_reg;
      always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset)
          word_reg <= C_RW_RESET;
        else if (wr_commit && rw_sel_reg[gi])
          word_reg <= (word_reg & ~wmask) | (wdata_reg & wmask);
      end
      assign rw_regs[32*gi +: 32] = word_reg;
    end
  endgenerate

  // ---------------- Sticky event register ----------------
  osnt_w1c_reg u_evt (
    .clk     (Bus2IP_Clk),
    .rst     (Bus2IP_Reset),
    .set_vec (evt_set),
    .clr_en  (wr_commit && evt_sel_reg),
    .clr_vec (wdata_reg),
    .be      (be_reg),
    .q       (evt_status)
  );

endmodule
